// File: rtl/fb_rect_filler_if.sv
// fb_rect_filler_if
//   Bundles the command channel, the framebuffer write channel and the
//   status outputs of fb_rect_filler. Clock and reset stay plain ports.
//   Parameters must match the fb_rect_filler instance they connect to.
//
//   Command channel : cmd_valid_i / cmd_ready_o, cmd_x0_i, cmd_y0_i,
//                     cmd_x1_i, cmd_y1_i (inclusive corners), cmd_color_i
//   Write channel   : fb_wr_en_o / fb_wr_ready_i, fb_wr_x_o, fb_wr_y_o,
//                     fb_wr_color_o
//   Sync / status   : frame_start_i, busy_o, done_o
//
//   modport slave  : filler side (drives *_o, reads *_i)
//   modport master : command source / arbiter / bench side
interface fb_rect_filler_if #(
  parameter int FB_WIDTH   = 400,
  parameter int FB_HEIGHT  = 300,
  parameter int COLOR_BITS = 12
);
  localparam int X_BITS = $clog2(FB_WIDTH);
  localparam int Y_BITS = $clog2(FB_HEIGHT);

  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic [X_BITS-1:0]     cmd_x0_i;
  logic [Y_BITS-1:0]     cmd_y0_i;
  logic [X_BITS-1:0]     cmd_x1_i;
  logic [Y_BITS-1:0]     cmd_y1_i;
  logic [COLOR_BITS-1:0] cmd_color_i;
  logic                  frame_start_i;
  logic                  fb_wr_en_o;
  logic [X_BITS-1:0]     fb_wr_x_o;
  logic [Y_BITS-1:0]     fb_wr_y_o;
  logic [COLOR_BITS-1:0] fb_wr_color_o;
  logic                  fb_wr_ready_i;
  logic                  busy_o;
  logic                  done_o;

  modport slave (
    input  cmd_valid_i, cmd_x0_i, cmd_y0_i, cmd_x1_i, cmd_y1_i, cmd_color_i,
    input  frame_start_i, fb_wr_ready_i,
    output cmd_ready_o, fb_wr_en_o, fb_wr_x_o, fb_wr_y_o, fb_wr_color_o,
    output busy_o, done_o
  );

  modport master (
    output cmd_valid_i, cmd_x0_i, cmd_y0_i, cmd_x1_i, cmd_y1_i, cmd_color_i,
    output frame_start_i, fb_wr_ready_i,
    input  cmd_ready_o, fb_wr_en_o, fb_wr_x_o, fb_wr_y_o, fb_wr_color_o,
    input  busy_o, done_o
  );
endinterface

// File: rtl/fb_rect_filler.sv
// fb_rect_filler
//   Framebuffer write-side engine. Accepts one rectangle-fill command at a
//   time, clamps it to the framebuffer, and issues one write per pixel in
//   raster order (left to right, top to bottom) to the write-port arbiter.
//
//   Ports:
//     clk_i    : system clock
//     reset_i  : synchronous, active-high reset
//     bus      : fb_rect_filler_if.slave (command, write and status signals)
//
//   Optional feature: define FB_RECT_FILLER_VSYNC_WAIT_EN to hold each
//   non-empty command in WAIT_VS until the next frame_start_i pulse, so the
//   fill starts at the beginning of vertical blank.
module fb_rect_filler #(
  parameter int FB_WIDTH   = 400,
  parameter int FB_HEIGHT  = 300,
  parameter int COLOR_BITS = 12
) (
  input  logic              clk_i,
  input  logic              reset_i,
  fb_rect_filler_if.slave   bus
);
  localparam int X_BITS = $clog2(FB_WIDTH);
  localparam int Y_BITS = $clog2(FB_HEIGHT);
  localparam logic [X_BITS-1:0] LP_X_MAX = X_BITS'(FB_WIDTH - 1);
  localparam logic [Y_BITS-1:0] LP_Y_MAX = Y_BITS'(FB_HEIGHT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
`ifdef FB_RECT_FILLER_VSYNC_WAIT_EN
    ST_WAIT_VS,
`endif
    ST_FILL,
    ST_DONE
  } state_t;

  state_t                r_state;
  state_t                w_state_next;

  logic [X_BITS-1:0]     r_x0;
  logic [X_BITS-1:0]     r_x1c;
  logic [Y_BITS-1:0]     r_y1c;
  logic [X_BITS-1:0]     r_x;
  logic [Y_BITS-1:0]     r_y;
  logic [COLOR_BITS-1:0] r_color;
  logic                  r_wr_en;

  logic [X_BITS-1:0]     w_x1c;
  logic [Y_BITS-1:0]     w_y1c;
  logic                  w_empty;
  logic                  w_accept_cmd;
  logic                  w_wr_acc;
  logic                  w_row_end;
  logic                  w_last;

  // Clamp the far corner to the framebuffer; a start corner outside the
  // framebuffer or past the clamped far corner means nothing to draw.
  assign w_x1c = (bus.cmd_x1_i > LP_X_MAX) ? LP_X_MAX : bus.cmd_x1_i;
  assign w_y1c = (bus.cmd_y1_i > LP_Y_MAX) ? LP_Y_MAX : bus.cmd_y1_i;
  assign w_empty = (bus.cmd_x0_i > LP_X_MAX) | (bus.cmd_y0_i > LP_Y_MAX) |
                   (bus.cmd_x0_i > w_x1c)    | (bus.cmd_y0_i > w_y1c);

  assign w_accept_cmd = bus.cmd_valid_i & (r_state == ST_IDLE);
  assign w_wr_acc     = r_wr_en & bus.fb_wr_ready_i;
  assign w_row_end    = (r_x == r_x1c);
  assign w_last       = w_row_end & (r_y == r_y1c);

`ifndef FB_RECT_FILLER_VSYNC_WAIT_EN
  logic w_unused_frame_start;
  assign w_unused_frame_start = bus.frame_start_i;
`endif

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept_cmd) begin
          if (w_empty) begin
            w_state_next = ST_DONE;
          end else begin
`ifdef FB_RECT_FILLER_VSYNC_WAIT_EN
            w_state_next = ST_WAIT_VS;
`else
            w_state_next = ST_FILL;
`endif
          end
        end
      end
`ifdef FB_RECT_FILLER_VSYNC_WAIT_EN
      ST_WAIT_VS: if (bus.frame_start_i) w_state_next = ST_FILL;
`endif
      ST_FILL: if (w_wr_acc && w_last) w_state_next = ST_DONE;
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    bus.cmd_ready_o = (r_state == ST_IDLE);
    bus.busy_o      = (r_state != ST_IDLE);
    bus.done_o      = (r_state == ST_DONE);
  end

  // Write-channel registers. The request flag tracks the upcoming state so
  // it rises together with entry to FILL and falls with the final accept.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_x0    <= '0;
      r_x1c   <= '0;
      r_y1c   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_color <= '0;
      r_wr_en <= 1'b0;
    end else begin
      r_wr_en <= (w_state_next == ST_FILL);
      case (r_state)
        ST_IDLE: begin
          if (w_accept_cmd && !w_empty) begin
            r_x0    <= bus.cmd_x0_i;
            r_x1c   <= w_x1c;
            r_y1c   <= w_y1c;
            r_x     <= bus.cmd_x0_i;
            r_y     <= bus.cmd_y0_i;
            r_color <= bus.cmd_color_i;
          end
        end
        ST_FILL: begin
          if (w_wr_acc && !w_last) begin
            if (w_row_end) begin
              r_x <= r_x0;
              r_y <= r_y + Y_BITS'(1);
            end else begin
              r_x <= r_x + X_BITS'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.fb_wr_en_o    = r_wr_en;
  assign bus.fb_wr_x_o     = r_x;
  assign bus.fb_wr_y_o     = r_y;
  assign bus.fb_wr_color_o = r_color;

endmodule

// File: tb/tb_fb_rect_filler.sv
// tb_fb_rect_filler
//   Directed and randomized rectangle fills against an expected-pixel list
//   built from the clamped rectangle with plain nested loops.
module tb_fb_rect_filler;
  localparam int W  = 400;
  localparam int H  = 300;
  localparam int CB = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;

  fb_rect_filler_if #(.FB_WIDTH(W), .FB_HEIGHT(H), .COLOR_BITS(CB)) bus ();

  fb_rect_filler #(.FB_WIDTH(W), .FB_HEIGHT(H), .COLOR_BITS(CB)) dut (
    .clk_i  (clk),
    .reset_i(rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // mode 0: ready always high, 1: ready pattern 1,0,0,..., 2: random ready
  task automatic run_cmd(input int x0, input int y0, input int x1, input int y1,
                         input int col, input int mode);
    int x1c, y1c, budget, t;
    int q[$];
    bit fin, rdy;
    x1c = (x1 > W - 1) ? W - 1 : x1;
    y1c = (y1 > H - 1) ? H - 1 : y1;
    if (!(x0 >= W || y0 >= H || x0 > x1c || y0 > y1c))
      for (int y = y0; y <= y1c; y++)
        for (int x = x0; x <= x1c; x++)
          q.push_back((x << 21) | (y << 12) | col);
    budget = q.size() * 8 + 20;

    chk("cmd_ready_idle", {31'b0, bus.cmd_ready_o}, 32'd1);
    bus.cmd_valid_i   = 1'b1;
    bus.cmd_x0_i      = x0[8:0];
    bus.cmd_y0_i      = y0[8:0];
    bus.cmd_x1_i      = x1[8:0];
    bus.cmd_y1_i      = y1[8:0];
    bus.cmd_color_i   = col[11:0];
    bus.fb_wr_ready_i = 1'b0;
`ifdef FB_RECT_FILLER_VSYNC_WAIT_EN
    bus.frame_start_i = 1'($urandom_range(0, 1));
`endif
    step;
    bus.cmd_valid_i   = 1'b0;
    bus.frame_start_i = 1'b0;
    bus.cmd_x0_i      = 9'($urandom);
    bus.cmd_y0_i      = 9'($urandom);
    bus.cmd_x1_i      = 9'($urandom);
    bus.cmd_y1_i      = 9'($urandom);
    bus.cmd_color_i   = 12'($urandom);
`ifdef FB_RECT_FILLER_VSYNC_WAIT_EN
    if (q.size() > 0) begin
      repeat ($urandom_range(1, 4)) begin
        chk("wait_vs_no_wr", {31'b0, bus.fb_wr_en_o}, 32'd0);
        chk("wait_vs_busy", {31'b0, bus.busy_o}, 32'd1);
        step;
      end
      bus.frame_start_i = 1'b1;
      chk("wait_vs_no_wr_at_pulse", {31'b0, bus.fb_wr_en_o}, 32'd0);
      step;
      bus.frame_start_i = 1'b0;
    end
`endif
    fin = 1'b0;
    for (t = 1; t <= budget && !fin; t++) begin
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? ((t - 1) % 3 == 0) : ($urandom_range(0, 3) != 0);
      bus.fb_wr_ready_i = rdy;
      if (q.size() == 0) begin
        chk("wr_en_after_last", {31'b0, bus.fb_wr_en_o}, 32'd0);
        chk("done_pulse", {31'b0, bus.done_o}, 32'd1);
        chk("ready_low_in_done", {31'b0, bus.cmd_ready_o}, 32'd0);
        fin = 1'b1;
      end else begin
        chk("wr_en", {31'b0, bus.fb_wr_en_o}, 32'd1);
        chk("wr_pixel", {2'b0, bus.fb_wr_x_o, bus.fb_wr_y_o, bus.fb_wr_color_o}, q[0]);
        chk("no_early_done", {31'b0, bus.done_o}, 32'd0);
        chk("busy_in_fill", {31'b0, bus.busy_o}, 32'd1);
        if (rdy && bus.fb_wr_en_o) void'(q.pop_front());
      end
      step;
    end
    bus.fb_wr_ready_i = 1'b0;
    chk("cmd_completes", {31'b0, fin}, 32'd1);
    chk("done_one_cycle", {31'b0, bus.done_o}, 32'd0);
    chk("ready_after_done", {31'b0, bus.cmd_ready_o}, 32'd1);
    chk("idle_not_busy", {31'b0, bus.busy_o}, 32'd0);
  endtask

  initial begin
    int x0, y0, x1, y1;
    bus.cmd_valid_i   = 1'b0;
    bus.cmd_x0_i      = '0;
    bus.cmd_y0_i      = '0;
    bus.cmd_x1_i      = '0;
    bus.cmd_y1_i      = '0;
    bus.cmd_color_i   = '0;
    bus.frame_start_i = 1'b0;
    bus.fb_wr_ready_i = 1'b0;

    rst = 1'b1;
    step;
    step;
    chk("rst_wr_en", {31'b0, bus.fb_wr_en_o}, 32'd0);
    chk("rst_wr_xy", {14'b0, bus.fb_wr_x_o, bus.fb_wr_y_o}, 32'd0);
    chk("rst_wr_color", {20'b0, bus.fb_wr_color_o}, 32'd0);
    chk("rst_busy", {31'b0, bus.busy_o}, 32'd0);
    chk("rst_done", {31'b0, bus.done_o}, 32'd0);
    chk("rst_ready", {31'b0, bus.cmd_ready_o}, 32'd1);
    rst = 1'b0;
    step;

    // Directed cases
    run_cmd(10, 20, 11, 21, 'hF00, 0);
    run_cmd(10, 20, 11, 21, 'hF00, 1);
    run_cmd(398, 299, 511, 511, 'h0A5, 0);
    run_cmd(5, 5, 4, 9, 'h123, 0);
    run_cmd(400, 0, 400, 0, 'h456, 0);
    run_cmd(0, 0, 0, 0, 'hFFF, 2);

    // Reset in the middle of a 10x10 fill
    bus.cmd_valid_i   = 1'b1;
    bus.cmd_x0_i      = 9'd20;
    bus.cmd_y0_i      = 9'd30;
    bus.cmd_x1_i      = 9'd29;
    bus.cmd_y1_i      = 9'd39;
    bus.cmd_color_i   = 12'h3C3;
    bus.fb_wr_ready_i = 1'b1;
    step;
    bus.cmd_valid_i = 1'b0;
`ifdef FB_RECT_FILLER_VSYNC_WAIT_EN
    bus.frame_start_i = 1'b1;
    step;
    bus.frame_start_i = 1'b0;
`endif
    step;
    step;
    chk("mid_fill_writing", {31'b0, bus.fb_wr_en_o}, 32'd1);
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("rst_mid_wr_en", {31'b0, bus.fb_wr_en_o}, 32'd0);
    chk("rst_mid_busy", {31'b0, bus.busy_o}, 32'd0);
    repeat (4) begin
      step;
      chk("rst_mid_no_done", {31'b0, bus.done_o}, 32'd0);
      chk("rst_mid_no_wr", {31'b0, bus.fb_wr_en_o}, 32'd0);
    end
    bus.fb_wr_ready_i = 1'b0;
    run_cmd(7, 8, 7, 8, 'h0F0, 0);

    // Randomized commands, biased toward the clipping edges and empties
    repeat (30) begin
      x0 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(390, 405)) : int'($urandom_range(0, 399));
      y0 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(290, 305)) : int'($urandom_range(0, 299));
      x1 = ($urandom_range(0, 7) == 0) ? 511 : x0 + int'($urandom_range(0, 6)) - 1;
      y1 = ($urandom_range(0, 7) == 0) ? 511 : y0 + int'($urandom_range(0, 5)) - 1;
      if (x1 < 0) x1 = 0;
      if (y1 < 0) y1 = 0;
      if (x1 > 511) x1 = 511;
      if (y1 > 511) y1 = 511;
      run_cmd(x0, y0, x1, y1, int'($urandom_range(0, 4095)), int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
